// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: default sizing, butterfly mode encoding
// and the single-correction modular add/sub/half helpers used by every PE.
package ntt_pkg;

  localparam int DEFAULT_DATA_W = 12;
  localparam int DEFAULT_Q      = 3329;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  // Helpers work on a wide word so any PE width fits; callers size-cast back.
  localparam int FN_W = 32;
  typedef logic [FN_W-1:0] word_t;

  function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
    logic [FN_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    return word_t'(sum);
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
    logic [FN_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[FN_W]) diff = diff + {1'b0, q};
    return word_t'(diff);
  endfunction

  // Odd x: x+Q is even because Q is odd, so the shift is exact.
  function automatic word_t mod_half(input word_t x, input word_t q);
    logic [FN_W:0] tmp;
    tmp = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return word_t'(tmp >> 1);
  endfunction

endpackage

// File: rtl/modmul_pipe.sv
// Pipelined modular multiplier p = a*b mod Q with a fixed latency of MUL_LAT
// registers, all cleared by reset.
module modmul_pipe #(
  parameter int DATA_W  = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);
  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] prod_mod;
  logic [DATA_W-1:0] pipe [MUL_LAT];

  always_comb begin
    prod     = PROD_W'(a) * PROD_W'(b);
    prod_mod = DATA_W'(prod % PROD_W'(Q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod_mod;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[MUL_LAT-1];

endmodule

// File: rtl/pe_bf_unified.sv
// Unified CT/GS radix-2 butterfly PE: mode and half_en travel with each
// sample, one shared multiplier, fixed latency MUL_LAT+3, one sample per cycle.
module pe_bf_unified
  import ntt_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int Q       = DEFAULT_Q,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] u,
  input  logic [DATA_W-1:0] v,
  input  logic [DATA_W-1:0] w,
  input  logic              mode,
  input  logic              half_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] bf_upper,
  output logic [DATA_W-1:0] bf_lower
);
  localparam int L = MUL_LAT + 3;

  logic [DATA_W-1:0] u1, v1, w1;
  bf_mode_e          mode1;
  logic              half1;
  logic [DATA_W-1:0] sum1, diff1;

  logic [DATA_W-1:0] a2, x2, w2;
  bf_mode_e          mode2;
  logic              half2;

  logic [DATA_W-1:0] x_dl    [MUL_LAT];
  bf_mode_e          mode_dl [MUL_LAT];
  logic              half_dl [MUL_LAT];

  logic [DATA_W-1:0] t_mul, upper_n, lower_n;
  logic [L-1:0]      vld;

  always_comb begin
    sum1  = DATA_W'(mod_add(word_t'(u1), word_t'(v1), word_t'(Q)));
    diff1 = DATA_W'(mod_sub(word_t'(u1), word_t'(v1), word_t'(Q)));
  end

  // Both modes reach the multiplier at the same stage, so mixed CT/GS streams
  // share it without collisions; x carries u (CT) or s (GS) alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u1    <= '0;
      v1    <= '0;
      w1    <= '0;
      mode1 <= BF_CT;
      half1 <= 1'b0;
      a2    <= '0;
      x2    <= '0;
      w2    <= '0;
      mode2 <= BF_CT;
      half2 <= 1'b0;
    end else begin
      u1    <= u;
      v1    <= v;
      w1    <= w;
      mode1 <= bf_mode_e'(mode);
      half1 <= half_en;
      a2    <= (mode1 == BF_GS) ? diff1 : v1;
      x2    <= (mode1 == BF_GS) ? sum1 : u1;
      w2    <= w1;
      mode2 <= mode1;
      half2 <= half1;
    end
  end

  modmul_pipe #(
    .DATA_W (DATA_W),
    .Q      (Q),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .a  (a2),
    .b  (w2),
    .p  (t_mul)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        x_dl[i]    <= '0;
        mode_dl[i] <= BF_CT;
        half_dl[i] <= 1'b0;
      end
    end else begin
      x_dl[0]    <= x2;
      mode_dl[0] <= mode2;
      half_dl[0] <= half2;
      for (int i = 1; i < MUL_LAT; i++) begin
        x_dl[i]    <= x_dl[i-1];
        mode_dl[i] <= mode_dl[i-1];
        half_dl[i] <= half_dl[i-1];
      end
    end
  end

  always_comb begin
    upper_n = x_dl[MUL_LAT-1];
    lower_n = t_mul;
    if (mode_dl[MUL_LAT-1] == BF_CT) begin
      upper_n = DATA_W'(mod_add(word_t'(x_dl[MUL_LAT-1]), word_t'(t_mul), word_t'(Q)));
      lower_n = DATA_W'(mod_sub(word_t'(x_dl[MUL_LAT-1]), word_t'(t_mul), word_t'(Q)));
    end else if (half_dl[MUL_LAT-1]) begin
      upper_n = DATA_W'(mod_half(word_t'(x_dl[MUL_LAT-1]), word_t'(Q)));
      lower_n = DATA_W'(mod_half(word_t'(t_mul), word_t'(Q)));
    end
  end

  // Results only load for a valid sample; otherwise the last result is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld      <= '0;
      bf_upper <= '0;
      bf_lower <= '0;
    end else begin
      vld <= {vld[L-2:0], in_valid};
      if (vld[L-2]) begin
        bf_upper <= upper_n;
        bf_lower <= lower_n;
      end
    end
  end

  assign out_valid = vld[L-1];

endmodule

// File: tb/tb_pe_bf_unified.sv
// Directed bench for pe_bf_unified: CT/GS vectors, mixed stream with a gap,
// and asynchronous reset while samples are in flight.
module tb_pe_bf_unified;
  localparam int DATA_W  = 12;
  localparam int Q       = 3329;
  localparam int MUL_LAT = 4;
  localparam int L       = MUL_LAT + 3;
  localparam int NS      = 23;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              in_valid = 1'b0;
  logic              mode     = 1'b0;
  logic              half_en  = 1'b0;
  logic [DATA_W-1:0] u        = '0;
  logic [DATA_W-1:0] v        = '0;
  logic [DATA_W-1:0] w        = '0;
  logic              out_valid;
  logic [DATA_W-1:0] bf_upper;
  logic [DATA_W-1:0] bf_lower;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] hold_up = '0;
  logic [DATA_W-1:0] hold_lo = '0;

  int                su [NS];
  int                sv [NS];
  int                sw [NS];
  logic              sm [NS];
  logic              sh [NS];
  logic              sval [NS];
  logic [DATA_W-1:0] eu [NS];
  logic [DATA_W-1:0] el [NS];

  always #5 clk = ~clk;

  pe_bf_unified #(
    .DATA_W (DATA_W),
    .Q      (Q),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .u        (u),
    .v        (v),
    .w        (w),
    .mode     (mode),
    .half_en  (half_en),
    .out_valid(out_valid),
    .bf_upper (bf_upper),
    .bf_lower (bf_lower)
  );

  function automatic int half_mod(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  function automatic void bf_model(input int uu, input int vv, input int ww,
                                   input logic m, input logic h,
                                   output logic [DATA_W-1:0] up_o,
                                   output logic [DATA_W-1:0] lo_o);
    int t, s, d;
    if (!m) begin
      t    = (vv * ww) % Q;
      up_o = DATA_W'((uu + t) % Q);
      lo_o = DATA_W'((uu - t + Q) % Q);
    end else begin
      s = (uu + vv) % Q;
      d = ((uu - vv + Q) % Q * ww) % Q;
      if (h) begin
        s = half_mod(s);
        d = half_mod(d);
      end
      up_o = DATA_W'(s);
      lo_o = DATA_W'(d);
    end
  endfunction

  task automatic applyStimulus(input logic vld, input int uu, input int vv, input int ww,
                               input logic m, input logic h);
    in_valid = vld;
    u        = DATA_W'(uu);
    v        = DATA_W'(vv);
    w        = DATA_W'(ww);
    mode     = m;
    half_en  = h;
  endtask

  task automatic checkOutput(input string tag, input logic exp_v,
                             input logic [DATA_W-1:0] exp_u,
                             input logic [DATA_W-1:0] exp_l);
    tests_run++;
    assert (out_valid === exp_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_v);
    end
    tests_run++;
    assert (bf_upper === exp_u) else begin
      tests_failed++;
      $error("[TB] FAIL %s bf_upper: got %0d expected %0d", tag, bf_upper, exp_u);
    end
    tests_run++;
    assert (bf_lower === exp_l) else begin
      tests_failed++;
      $error("[TB] FAIL %s bf_lower: got %0d expected %0d", tag, bf_lower, exp_l);
    end
  endtask

  // One isolated sample: nothing until +L, a one-cycle pulse at +L, then hold.
  task automatic run_single(input string tag, input int uu, input int vv, input int ww,
                            input logic m, input logic h,
                            input logic [DATA_W-1:0] exp_u, input logic [DATA_W-1:0] exp_l);
    @(negedge clk);
    applyStimulus(1'b1, uu, vv, ww, m, h);
    for (int i = 1; i <= L + 1; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
      if (i < L) checkOutput($sformatf("%s_c%0d", tag, i), 1'b0, hold_up, hold_lo);
      else checkOutput($sformatf("%s_c%0d", tag, i), (i == L), exp_u, exp_l);
    end
    hold_up = exp_u;
    hold_lo = exp_l;
  endtask

  initial begin
    int k;
    logic exp_v;

    $display("[TB] start");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    checkOutput("reset", 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_single("ct_basic", 100, 2, 17, 1'b0, 1'b0, 12'd134, 12'd66);
    run_single("ct_wrap", 3300, 100, 1, 1'b0, 1'b0, 12'd71, 12'd3200);
    run_single("gs_nohalf", 10, 20, 17, 1'b1, 1'b0, 12'd30, 12'd3159);
    run_single("gs_half", 10, 20, 17, 1'b1, 1'b1, 12'd15, 12'd3244);
    run_single("ct_halfignored", 100, 2, 17, 1'b0, 1'b1, 12'd134, 12'd66);

    // Mixed stream: 20 samples alternating CT/GS with a 3-cycle gap after 10.
    k = 0;
    for (int c = 0; c < NS; c++) begin
      sval[c] = !(c >= 10 && c < 13);
      su[c]   = int'($urandom_range(Q - 1));
      sv[c]   = int'($urandom_range(Q - 1));
      sw[c]   = int'($urandom_range(Q - 1));
      sm[c]   = (k % 2) == 1;
      sh[c]   = $urandom_range(1) == 1;
      bf_model(su[c], sv[c], sw[c], sm[c], sh[c], eu[c], el[c]);
      if (sval[c]) k++;
    end
    for (int c = 0; c <= NS + L; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (c >= L && c - L < NS) begin
        if (sval[c - L]) begin
          exp_v   = 1'b1;
          hold_up = eu[c - L];
          hold_lo = el[c - L];
        end
      end
      checkOutput($sformatf("stream_c%0d", c), exp_v, hold_up, hold_lo);
      if (c < NS) applyStimulus(sval[c], su[c], sv[c], sw[c], sm[c], sh[c]);
      else applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    end

    // Reset while five samples are in flight.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1000 + i, 200 + i, 300 + i, (i % 2) == 1, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("pre_rst", 1'b0, hold_up, hold_lo);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_immediate", 1'b0, '0, '0);
    hold_up = '0;
    hold_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("no_stale_%0d", i), 1'b0, '0, '0);
    end
    run_single("post_rst", 5, 7, 3, 1'b0, 1'b0, 12'd26, 12'd3313);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
